// File: rtl/unum4_unpack.sv
// unum4_unpack: 3-stage pipelined unum4 word decoder (exponent, normalized mantissa, zero/special flags)
module unum4_unpack #(
  parameter int DATA_W    = 32,
  parameter int MAN_MAX_W = 29,
  parameter int EXP_SZ_W  = 4,
  parameter int EXP_MAX_W = 16,
  parameter int EXTRA     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_W-1:0]          in,
  output logic                       done,
  output logic [EXP_MAX_W-1:0]       exp,
  output logic [MAN_MAX_W+EXTRA-1:0] mant,
  output logic                       zero,
  output logic                       special
);
  localparam int F  = DATA_W - EXP_SZ_W;
  localparam int SW = $clog2(DATA_W + 1);
  localparam logic [EXP_SZ_W-1:0] ES_MAX = '1;
  logic                v1, v2, spec2, zero2, neg2;
  logic [DATA_W-1:0]   w1;
  logic [EXP_SZ_W-1:0] es;
  logic [SW-1:0]       sh;
  logic [DATA_W-1:0]   e_full;
  logic [EXP_MAX_W-1:0] e2;
  logic [F-1:0]        f_sh, f2;
  logic                top;
  assign es = w1[EXP_SZ_W-1:0];
  assign sh = SW'(DATA_W) - SW'(es);
  // Arithmetic shift of the whole word leaves E sign-extended in the low bits.
  assign e_full = (es == '0) ? '0 : DATA_W'($signed(w1) >>> sh);
  assign f_sh = w1[DATA_W-1:EXP_SZ_W] << es;
  assign top = spec2 ? f2[F-1] : ~f2[F-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      w1 <= '0;
      v2 <= 1'b0;
      spec2 <= 1'b0;
      zero2 <= 1'b0;
      neg2 <= 1'b0;
      e2 <= '0;
      f2 <= '0;
      done <= 1'b0;
      exp <= '0;
      mant <= '0;
      zero <= 1'b0;
      special <= 1'b0;
    end else begin
      v1 <= start;
      w1 <= in;
      v2 <= v1;
      spec2 <= (es == ES_MAX);
      zero2 <= (w1 == '0);
      neg2 <= (es != '0) && w1[DATA_W-1];
      e2 <= e_full[EXP_MAX_W-1:0];
      f2 <= f_sh;
      done <= v2;
      if (v2) begin
        exp <= e2 + EXP_MAX_W'(neg2 && !spec2);
        mant <= zero2 ? '0 : {top, f2, {EXTRA{1'b0}}};
        zero <= zero2;
        special <= spec2;
      end
    end
  end
endmodule

// File: tb/tb_unum4_unpack.sv
// tb_unum4_unpack: directed and randomized checks of unum4_unpack against a value-level model
module tb_unum4_unpack;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] in = '0;
  logic        done, zero, special;
  logic [15:0] exp;
  logic [31:0] mant;
  int checks = 0, failures = 0, cyc = 0;

  typedef struct {
    logic [15:0] e;
    logic [31:0] m;
    logic        z;
    logic        s;
    int          due;
  } res_t;

  res_t q[$];
  res_t last;

  unum4_unpack dut (
    .clk(clk), .rst(rst), .start(start), .in(in),
    .done(done), .exp(exp), .mant(mant), .zero(zero), .special(special)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [31:0] w);
    res_t r;
    int es;
    longint e, f;
    logic [28:0] m;
    r = '{e: '0, m: '0, z: 1'b0, s: 1'b0, due: 0};
    es = int'(w[3:0]);
    if (w == 0) begin
      r.z = 1'b1;
      return r;
    end
    e = 0;
    if (es != 0) begin
      e = longint'(w) / (longint'(1) << (32 - es));
      if (e >= (longint'(1) << (es - 1))) e -= (longint'(1) << es);
      if (es != 15 && e < 0) e += 1;
    end
    f = (longint'(w) / 16) % (longint'(1) << (28 - es));
    f = f * (longint'(1) << es);
    m[27:0] = f[27:0];
    m[28] = (es == 15) ? m[27] : ~m[27];
    r.e = e[15:0];
    r.m = {m, 3'b000};
    r.s = (es == 15);
    return r;
  endfunction

  function automatic res_t lit(logic [15:0] e, logic [31:0] m, logic z, logic s);
    res_t r;
    r = '{e: e, m: m, z: z, s: s, due: 0};
    return r;
  endfunction

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] xp);
    checks++;
    assert (obs === xp) else begin
      failures++;
      $error("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, xp);
    end
  endtask

  task automatic step();
    logic want_done;
    @(posedge clk);
    #1;
    cyc++;
    want_done = (q.size() != 0) && (q[0].due == cyc);
    if (want_done) last = q.pop_front();
    ck("done", 32'(done), 32'(want_done));
    ck("exp", 32'(exp), 32'(last.e));
    ck("mant", mant, last.m);
    ck("zero", 32'(zero), 32'(last.z));
    ck("special", 32'(special), 32'(last.s));
  endtask

  task automatic issue(input logic s, input logic [31:0] w, input res_t r);
    res_t t;
    start = s;
    in = w;
    if (s) begin
      t = r;
      t.due = cyc + 3;
      q.push_back(t);
    end
    step();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, $urandom, last);
  endtask

  task automatic do_reset(input logic st);
    rst = 1'b1;
    start = st;
    in = $urandom;
    q.delete();
    last = lit('0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    start = 1'b0;
  endtask

  res_t r2, r3, r4;
  logic [31:0] w;

  initial begin
    last = lit('0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset(1'b1);
    idle(4);
    issue(1'b1, 32'h0000_0000, lit(16'h0000, 32'h0000_0000, 1'b1, 1'b0));
    idle(4);
    issue(1'b1, 32'h8000_0000, lit(16'h0000, 32'h4000_0000, 1'b0, 1'b0));
    idle(4);
    issue(1'b1, 32'h6000_0002, lit(16'h0001, 32'h4000_0000, 1'b0, 1'b0));
    idle(4);
    issue(1'b1, 32'hA000_0002, lit(16'hFFFF, 32'h4000_0000, 1'b0, 1'b0));
    idle(4);
    issue(1'b1, 32'h0000_000F, lit(16'h0000, 32'h0000_0000, 1'b0, 1'b1));
    idle(4);
    r2 = lit(16'h0000, 32'h4000_0000, 1'b0, 1'b0);
    r3 = lit(16'h0001, 32'h4000_0000, 1'b0, 1'b0);
    r4 = lit(16'hFFFF, 32'h4000_0000, 1'b0, 1'b0);
    issue(1'b1, 32'h8000_0000, r2);
    issue(1'b1, 32'h6000_0002, r3);
    issue(1'b1, 32'hA000_0002, r4);
    idle(4);
    issue(1'b1, 32'h8000_0000, r2);
    issue(1'b1, 32'h6000_0002, r3);
    issue(1'b1, 32'hA000_0002, r4);
    do_reset(1'b0);
    idle(5);
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      else if ($urandom_range(0, 3) == 0) w[3:0] = 4'hF;
      issue($urandom_range(0, 3) != 0, w, model(w));
    end
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
